// File: rtl/serialula_pkg.sv
// Shared timing defaults and tone/data mapping for the serial ULA cassette path.
package serialula_pkg;

  localparam int LONG_THRESH_DEF     = 176;
  localparam int BURST0_POS_DEF      = 8;
  localparam int DCD_THRESH_FERRANTI = 962;
  localparam int DCD_THRESH_VLSI     = 445;
  localparam int BURST_TICKS         = 8;

  typedef enum logic {
    TONE_LOW  = 1'b0,
    TONE_HIGH = 1'b1
  } tone_e;

  // Data 1 is the high tone unless the mapping is reversed.
  function automatic tone_e data_to_tone(input logic data, input logic reverse);
    return (data ^ reverse) ? TONE_HIGH : TONE_LOW;
  endfunction

  function automatic logic tone_to_data(input tone_e tone, input logic reverse);
    return (tone == TONE_HIGH) ^ reverse;
  endfunction

endpackage

// File: rtl/cassette_fsk_codec_cas_edge_filter.sv
// Cassette input synchroniser, tick-rate glitch filter and one-tick edge pulse.
module cas_edge_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic cas_in,
  output logic edge_pulse
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          edge_q, edge_d;

  // The edge pulse is held until the next tick so the rx logic sees it exactly once.
  always_comb begin
    sync1_d = cas_in;
    sync2_d = sync1_q;
    filt_d  = filt_q;
    cnt_d   = cnt_q;
    edge_d  = edge_q;
    if (tick) begin
      edge_d = 1'b0;
      if (sync2_q != filt_q) begin
        if (cnt_q == CW'(FILTER_LEN - 1)) begin
          filt_d = ~filt_q;
          cnt_d  = {CW{1'b0}};
          edge_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else begin
        cnt_d = {CW{1'b0}};
      end
    end else begin
      edge_d = edge_q;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
    end
  end

  assign edge_pulse = edge_q;

endmodule

// File: rtl/cassette_fsk_codec.sv
// Cassette FSK modem: tone phase synthesis for the DAC, data/clock/DCD recovery from cas_in.
// Optional gap-error output rx_err is built when FSK_ERR_DETECT_EN is defined.
module cassette_fsk_codec
  import serialula_pkg::*;
#(
  parameter int TICK_DIV    = 2,
  parameter int FILTER_LEN  = 4,
  parameter int GAP_BITS    = 8,
  parameter int BURST0_POS  = BURST0_POS_DEF,
  parameter int LONG_THRESH = LONG_THRESH_DEF,
  parameter int BIT_LOG2    = 10,
  parameter int SINE_BITS   = 3,
  parameter int HT_BITS     = 10,
  parameter int DCD_THRESH  = DCD_THRESH_FERRANTI
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 motor_on,
  input  logic                 reverse_tones,
  input  logic                 tx_en,
  input  logic                 tx_data,
  output logic                 tx_bit_strobe,
  output logic                 tx_active,
  output logic [SINE_BITS-1:0] tx_phase,
  input  logic                 cas_in,
  output logic                 rx_clk,
  output logic                 rx_data,
  output logic                 dcd
`ifdef FSK_ERR_DETECT_EN
  , output logic               rx_err
`endif
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic                 tick_s;
  logic                 edge_s;
  logic [BIT_LOG2-1:0]  bit_cnt_q, bit_cnt_d;
  logic                 txd_q, txd_d;
  logic                 tx_active_q, tx_active_d;
  logic                 tx_bit_strobe_q, tx_bit_strobe_d;
  logic [SINE_BITS-1:0] tx_phase_q, tx_phase_d;
  logic [GAP_BITS-1:0]  gap_q, gap_d;
  logic                 burst_active_q, burst_active_d;
  logic [2:0]           burst_cnt_q, burst_cnt_d;
  logic                 burst_start_s;
  logic                 rx_clk_q, rx_clk_d;
  logic                 long_q, long_d;
  logic                 long_last_q, long_last_d;
  logic                 rx_data_q, rx_data_d;
  logic [HT_BITS-1:0]   ht_cnt_q, ht_cnt_d;
  logic                 dcd_q, dcd_d;
`ifdef FSK_ERR_DETECT_EN
  logic                 rx_err_q, rx_err_d;
`endif

  cas_edge_filter #(.FILTER_LEN(FILTER_LEN)) u_edge_filter (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick_s),
    .cas_in     (cas_in),
    .edge_pulse (edge_s)
  );

  // Receive sample tick divider.
  always_comb begin
    tick_s = (tick_cnt_q == TW'(TICK_DIV - 1));
    if (tick_s) begin
      tick_cnt_d = {TW{1'b0}};
    end else begin
      tick_cnt_d = tick_cnt_q + TW'(1);
    end
  end

  // Transmit: tx inputs are only sampled at the bit boundary so phase is 0 at every boundary.
  always_comb begin
    bit_cnt_d   = bit_cnt_q + BIT_LOG2'(1);
    txd_d       = txd_q;
    tx_active_d = tx_active_q;
    if (&bit_cnt_q) begin
      txd_d       = (data_to_tone(tx_data, reverse_tones) == TONE_HIGH);
      tx_active_d = tx_en;
    end else begin
      txd_d       = txd_q;
      tx_active_d = tx_active_q;
    end
    tx_bit_strobe_d = &bit_cnt_d;
    if (!tx_active_d) begin
      tx_phase_d = {SINE_BITS{1'b0}};
    end else if (txd_d) begin
      tx_phase_d = bit_cnt_d[BIT_LOG2-2 -: SINE_BITS];
    end else begin
      tx_phase_d = bit_cnt_d[BIT_LOG2-1 -: SINE_BITS];
    end
  end

  // Receive: gap measurement, clock bursts and data decision, all advancing on ticks.
  always_comb begin
    gap_d          = gap_q;
    burst_active_d = burst_active_q;
    burst_cnt_d    = burst_cnt_q;
    long_d         = long_q;
    long_last_d    = long_last_q;
    rx_data_d      = rx_data_q;
    burst_start_s  = (gap_q == GAP_BITS'(BURST0_POS)) || (gap_q == GAP_BITS'(LONG_THRESH));
    if (tick_s) begin
      if (edge_s) begin
        gap_d = {GAP_BITS{1'b0}};
      end else if (!(&gap_q)) begin
        gap_d = gap_q + GAP_BITS'(1);
      end else begin
        gap_d = gap_q;
      end
      if (burst_active_q) begin
        burst_cnt_d    = burst_cnt_q + 3'd1;
        burst_active_d = (burst_cnt_q != 3'(BURST_TICKS - 1));
      end else if (burst_start_s) begin
        burst_active_d = 1'b1;
        burst_cnt_d    = 3'd0;
      end else begin
        burst_active_d = 1'b0;
      end
      // An edge wins over the long threshold in the same tick.
      if (edge_s) begin
        long_last_d = long_q;
        long_d      = 1'b0;
        if (long_q) begin
          rx_data_d = tone_to_data(TONE_LOW, reverse_tones);
        end else if (!long_last_q) begin
          rx_data_d = tone_to_data(TONE_HIGH, reverse_tones);
        end else begin
          rx_data_d = rx_data_q;
        end
      end else if (gap_q == GAP_BITS'(LONG_THRESH)) begin
        long_d = 1'b1;
      end else begin
        long_d = long_q;
      end
    end else begin
      gap_d = gap_q;
    end
    rx_clk_d = ~(burst_active_d & burst_cnt_d[0]);
  end

  // Carrier detect: high-tone run length measured every 256 clk.
  always_comb begin
    ht_cnt_d = ht_cnt_q;
    dcd_d    = dcd_q;
    if (bit_cnt_q[7:0] == 8'hFF) begin
      if (!rx_data_q || !motor_on) begin
        ht_cnt_d = {HT_BITS{1'b0}};
      end else if (&ht_cnt_q) begin
        ht_cnt_d = ht_cnt_q;
      end else begin
        ht_cnt_d = ht_cnt_q + HT_BITS'(1);
      end
      dcd_d = (ht_cnt_d >= HT_BITS'(DCD_THRESH));
    end else begin
      dcd_d = dcd_q;
    end
  end

`ifdef FSK_ERR_DETECT_EN
  // Error pulse: residual glitch edge or first arrival at gap saturation.
  always_comb begin
    rx_err_d = rx_err_q;
    if (tick_s) begin
      rx_err_d = (edge_s && (gap_q < GAP_BITS'(4))) ||
                 (!edge_s && (gap_q == {{(GAP_BITS-1){1'b1}}, 1'b0}));
    end else begin
      rx_err_d = rx_err_q;
    end
  end
`endif

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q      <= {TW{1'b0}};
      bit_cnt_q       <= {BIT_LOG2{1'b0}};
      txd_q           <= 1'b0;
      tx_active_q     <= 1'b0;
      tx_bit_strobe_q <= 1'b0;
      tx_phase_q      <= {SINE_BITS{1'b0}};
      gap_q           <= {GAP_BITS{1'b0}};
      burst_active_q  <= 1'b0;
      burst_cnt_q     <= 3'd0;
      rx_clk_q        <= 1'b1;
      long_q          <= 1'b0;
      long_last_q     <= 1'b0;
      rx_data_q       <= 1'b1;
      ht_cnt_q        <= {HT_BITS{1'b0}};
      dcd_q           <= 1'b0;
`ifdef FSK_ERR_DETECT_EN
      rx_err_q        <= 1'b0;
`endif
    end else begin
      tick_cnt_q      <= tick_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      txd_q           <= txd_d;
      tx_active_q     <= tx_active_d;
      tx_bit_strobe_q <= tx_bit_strobe_d;
      tx_phase_q      <= tx_phase_d;
      gap_q           <= gap_d;
      burst_active_q  <= burst_active_d;
      burst_cnt_q     <= burst_cnt_d;
      rx_clk_q        <= rx_clk_d;
      long_q          <= long_d;
      long_last_q     <= long_last_d;
      rx_data_q       <= rx_data_d;
      ht_cnt_q        <= ht_cnt_d;
      dcd_q           <= dcd_d;
`ifdef FSK_ERR_DETECT_EN
      rx_err_q        <= rx_err_d;
`endif
    end
  end

  assign tx_bit_strobe = tx_bit_strobe_q;
  assign tx_active     = tx_active_q;
  assign tx_phase      = tx_phase_q;
  assign rx_clk        = rx_clk_q;
  assign rx_data       = rx_data_q;
  assign dcd           = dcd_q;
`ifdef FSK_ERR_DETECT_EN
  assign rx_err        = rx_err_q;
`endif

endmodule

// File: tb/tb_cassette_fsk_codec.sv
// Directed self-checking bench for cassette_fsk_codec (DCD_THRESH reduced to keep runtime short).
module tb_cassette_fsk_codec;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       motor_on = 1'b0;
  logic       reverse_tones = 1'b0;
  logic       tx_en = 1'b0;
  logic       tx_data = 1'b0;
  logic       tx_bit_strobe;
  logic       tx_active;
  logic [2:0] tx_phase;
  logic       cas_in = 1'b0;
  logic       rx_clk;
  logic       rx_data;
  logic       dcd;
`ifdef FSK_ERR_DETECT_EN
  logic       rx_err;
  int         err_cnt = 0;
  logic       rx_err_prev = 1'b0;
`endif

  int   n_checks = 0;
  int   n_fail = 0;
  int   fall_cnt = 0;
  logic rx_clk_prev = 1'b1;
  int   snap;

  always #5 clk = ~clk;

  cassette_fsk_codec #(.DCD_THRESH(6)) dut (
    .clk           (clk),
    .reset         (reset),
    .motor_on      (motor_on),
    .reverse_tones (reverse_tones),
    .tx_en         (tx_en),
    .tx_data       (tx_data),
    .tx_bit_strobe (tx_bit_strobe),
    .tx_active     (tx_active),
    .tx_phase      (tx_phase),
    .cas_in        (cas_in),
    .rx_clk        (rx_clk),
    .rx_data       (rx_data),
    .dcd           (dcd)
`ifdef FSK_ERR_DETECT_EN
    , .rx_err      (rx_err)
`endif
  );

  // Count rx_clk low pulses (falling transitions).
  always @(negedge clk) begin
    if (rx_clk_prev === 1'b1 && rx_clk === 1'b0) fall_cnt <= fall_cnt + 1;
    rx_clk_prev <= rx_clk;
  end

`ifdef FSK_ERR_DETECT_EN
  // Count rx_err pulses.
  always @(negedge clk) begin
    if (rx_err_prev === 1'b0 && rx_err === 1'b1) err_cnt <= err_cnt + 1;
    rx_err_prev <= rx_err;
  end
`endif

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(3);
    reset = 1'b0;
  endtask

  task automatic wait_strobe();
    for (int k = 0; k < 1100 && tx_bit_strobe !== 1'b1; k++) step(1);
    check_eq("strobe_wait", tx_bit_strobe, 1);
  endtask

  task automatic toggle();
    cas_in = ~cas_in;
  endtask

  initial begin
    // Reset state
    tx_en = 1'b1;
    tx_data = 1'b0;
    step(4);
    check_eq("rst_rx_clk", rx_clk, 1);
    check_eq("rst_rx_data", rx_data, 1);
    check_eq("rst_dcd", dcd, 0);
    check_eq("rst_tx_active", tx_active, 0);
    check_eq("rst_tx_phase", tx_phase, 0);
    check_eq("rst_strobe", tx_bit_strobe, 0);
    reset = 1'b0;

    // Transmit: low tone then high tone, then disable
    wait_strobe();
    check_eq("tx_idle_active", tx_active, 0);
    step(1);
    check_eq("tx_active_on", tx_active, 1);
    check_eq("tx_low_ph0", tx_phase, 0);
    check_eq("tx_strobe_off", tx_bit_strobe, 0);
    step(127);
    check_eq("tx_low_127", tx_phase, 0);
    step(1);
    check_eq("tx_low_128", tx_phase, 1);
    step(172);
    tx_data = 1'b1;
    step(84);
    check_eq("tx_low_384_midbit", tx_phase, 3);
    step(639);
    check_eq("tx_strobe_1024", tx_bit_strobe, 1);
    step(1);
    check_eq("tx_high_ph0", tx_phase, 0);
    step(64);
    check_eq("tx_high_64", tx_phase, 1);
    step(512);
    check_eq("tx_high_576", tx_phase, 1);
    tx_en = 1'b0;
    step(446);
    check_eq("tx_strobe_1022", tx_bit_strobe, 0);
    step(1);
    check_eq("tx_strobe_1023", tx_bit_strobe, 1);
    step(1);
    check_eq("tx_active_off", tx_active, 0);
    step(200);
    check_eq("tx_off_phase", tx_phase, 0);

    // Carrier detect with threshold 6
    motor_on = 1'b1;
    do_reset();
    wait_strobe();
    step(1);
    step(511);
    check_eq("dcd_early", dcd, 0);
    step(1);
    check_eq("dcd_rise", dcd, 1);
    motor_on = 1'b0;
    step(255);
    check_eq("dcd_hold", dcd, 1);
    step(1);
    check_eq("dcd_motor_off", dcd, 0);

    // Long gaps: 512 clk per half cycle
    cas_in = 1'b0;
    do_reset();
    step(512);
    toggle();
    snap = fall_cnt;
    step(100);
    check_eq("long_first_edge", rx_data, 0);
    step(412);
    toggle();
    step(512);
    check_eq("long_pulses", fall_cnt - snap, 16);
    toggle();
    // Glitch of 2 ticks must not create an edge
    step(150);
    snap = fall_cnt;
    toggle();
    step(4);
    toggle();
    step(150);
    check_eq("glitch_no_burst", fall_cnt - snap, 0);
    check_eq("glitch_data", rx_data, 0);
    // Short gaps: 256 clk per half cycle
    step(208);
    toggle();
    step(256);
    toggle();
    step(100);
    check_eq("short_first_hold", rx_data, 0);
    step(156);
    toggle();
    snap = fall_cnt;
    step(100);
    check_eq("short_second", rx_data, 1);
    step(156);
    toggle();
    step(256);
    toggle();
    step(256);
    toggle();
    step(256);
    check_eq("short_pulses", fall_cnt - snap, 16);

    // Reversed tone mapping
    cas_in = 1'b0;
    reverse_tones = 1'b1;
    do_reset();
    step(512);
    toggle();
    step(100);
    check_eq("rev_long", rx_data, 1);
    step(412);
    toggle();
    step(256);
    toggle();
    step(256);
    toggle();
    step(100);
    check_eq("rev_short", rx_data, 0);
    step(156);
    toggle();
    for (int k = 0; k < 200 && rx_clk !== 1'b0; k++) step(1);
    check_eq("burst_seen", rx_clk, 0);
    check_eq("rev_short2", rx_data, 0);
    reset = 1'b1;
    step(1);
    check_eq("reset_burst_clk", rx_clk, 1);
    check_eq("reset_burst_data", rx_data, 1);
    reset = 1'b0;
    reverse_tones = 1'b0;

`ifdef FSK_ERR_DETECT_EN
    // Static input: one dropout error at gap saturation
    cas_in = 1'b0;
    do_reset();
    step(2);
    snap = err_cnt;
    step(600);
    check_eq("err_dropout", err_cnt - snap, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
